// File: rtl/seq_mult_param.sv
// -----------------------------------------------------------------------------
// seq_mult_param
//
// Parametrised sequential shift-add multiplier. Computes the exact
// 2*WIDTH-bit product of two WIDTH-bit operands, unsigned or two's-complement
// (selected per operation), over WIDTH clock cycles. This is the shared
// multiply unit for the datapath.
//
// Parameters:
//   WIDTH        operand width, legal range 2..32
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; accepted only while ready=1
//   signed_mode  1 = two's-complement operands, 0 = unsigned; sampled with start
//   a            multiplicand; sampled with start
//   b            multiplier; sampled with start
//   ready        high when no operation is in progress (~busy)
//   busy         high while iterating
//   done         one-cycle pulse; product holds the new result
//   product      registered result; held until the next completion
// -----------------------------------------------------------------------------
module seq_mult_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Working registers
  logic [WIDTH:0]       r_acc;      // one guard bit above the operand width
  logic [WIDTH-1:0]     r_mplr;     // multiplier, shifted right each iteration
  logic [WIDTH-1:0]     r_mcand;    // captured multiplicand
  logic [CntW-1:0]      r_cnt;      // iteration index 0..WIDTH-1
  logic                 r_signed;   // captured mode
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  // Combinational datapath
  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH:0]       w_mcand_ext;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_acc_shift;
  logic [WIDTH-1:0]     w_mplr_shift;
  logic [2*WIDTH-1:0]   w_result;

  assign w_accept = (r_state == StIdle) && start;
  assign w_last   = (r_state == StRun) && (r_cnt == LastCnt);

  // One guard bit: sign extension in signed mode, zero extension otherwise.
  assign w_mcand_ext = {r_signed & r_mcand[WIDTH-1], r_mcand};

  // The MSB of a two's-complement multiplier carries negative weight, so the
  // final partial product is subtracted rather than added.
  always_comb begin
    w_sum = r_acc;
    if (r_mplr[0]) begin
      if (w_last && r_signed) begin
        w_sum = r_acc - w_mcand_ext;
      end else begin
        w_sum = r_acc + w_mcand_ext;
      end
    end
  end

  // Right shift of {acc, mplr}: arithmetic in signed mode, logical otherwise.
  assign w_acc_shift  = {r_signed & w_sum[WIDTH], w_sum[WIDTH:1]};
  assign w_mplr_shift = {w_sum[0], r_mplr[WIDTH-1:1]};

  // Low 2*WIDTH bits of the shifted {acc, mplr}; the guard bit is dropped.
  assign w_result = {w_sum, r_mplr[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mplr    <= '0;
      r_mcand   <= '0;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_acc    <= '0;
        r_mplr   <= b;
        r_mcand  <= a;
        r_signed <= signed_mode;
        r_cnt    <= '0;
      end else if (r_state == StRun) begin
        r_acc  <= w_acc_shift;
        r_mplr <= w_mplr_shift;
        if (w_last) begin
          r_cnt     <= '0;
          r_product <= w_result;
          r_done    <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CntW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy    = (r_state == StRun);
  assign ready   = (r_state == StIdle);
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult_param.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_param
//
// Scoreboard bench for seq_mult_param at WIDTH = 2, 8, 16 and 32 in parallel.
// Each width has a driver that issues operations (directed corner operands,
// a reset abort, then random traffic including starts while busy) and pushes
// the expected product and completion edge into a queue, plus a monitor that
// checks every cycle's outputs against that queue.
// -----------------------------------------------------------------------------
module tb_seq_mult_param;

  typedef struct {
    logic [63:0] prod;
    int          acc;   // accepting edge index
    int          due;   // edge after which done must be high
  } exp_t;

  logic clk;
  int   edge_n;
  int   n_checks;
  int   n_fail;
  bit   fin [4];

  initial begin
    clk      = 1'b0;
    edge_n   = 0;
    n_checks = 0;
    n_fail   = 0;
  end

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_w
    localparam int W      = (gi == 0) ? 2 : (gi == 1) ? 8 : (gi == 2) ? 16 : 32;
    localparam int Target = (gi == 0) ? 4000 : (gi == 1) ? 3000 : (gi == 2) ? 2000 : 1200;

    logic             rst_n;
    logic             start;
    logic             signed_mode;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    exp_t             exp_q[$];
    logic [63:0]      last_prod;
    int               accepted;
    int               n_done;
    int               model_free;

    seq_mult_param #(.WIDTH(W)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .ready       (ready),
      .busy        (busy),
      .done        (done),
      .product     (product)
    );

    // Reference: plain integer multiplication, truncated to 2*W bits.
    function automatic logic [63:0] ref_mult(input logic sm, input logic [W-1:0] av,
                                             input logic [W-1:0] bv);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [2*W-1:0]  r;
      if (sm) begin
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        r  = (2*W)'(sa * sb);
      end else begin
        ua = 64'(av);
        ub = 64'(bv);
        r  = (2*W)'(ua * ub);
      end
      return 64'(r);
    endfunction

    function automatic logic [W-1:0] corner(input int idx);
      logic [W-1:0] v;
      case (idx)
        0:       v = '0;
        1:       v = '1;
        2:       v = {1'b1, {(W-1){1'b0}}};
        3:       v = {1'b0, {(W-1){1'b1}}};
        default: v = W'(1);
      endcase
      return v;
    endfunction

    function automatic logic [W-1:0] pick();
      int sel;
      sel = $urandom_range(0, 7);
      if (sel < 5) return W'($urandom);
      return corner(sel - 5);
    endfunction

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    // Waits for the model to be idle, then issues one operation.
    task automatic issue(input logic sm, input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      while (model_free > edge_n + 1) begin
        start = 1'b0;
        tick();
      end
      start       = 1'b1;
      signed_mode = sm;
      a           = av;
      b           = bv;
      e.prod      = ref_mult(sm, av, bv);
      e.acc       = edge_n + 1;
      e.due       = edge_n + 1 + W;
      exp_q.push_back(e);
      model_free  = edge_n + 2 + W;
      accepted++;
      tick();
      // Scramble inputs to show the operands were captured.
      start       = 1'b0;
      a           = W'($urandom);
      b           = W'($urandom);
      signed_mode = 1'($urandom);
    endtask

    // Driver
    initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      signed_mode = 1'b0;
      a           = '0;
      b           = '0;
      accepted    = 0;
      model_free  = 0;
      repeat (2) tick();
      rst_n      = 1'b1;
      model_free = edge_n + 1;

      for (int sm = 0; sm < 2; sm++) begin
        for (int i = 0; i < 5; i++) begin
          for (int j = 0; j < 5; j++) begin
            issue(1'(sm), corner(i), corner(j));
          end
        end
      end

      // Abort an operation halfway through with an asynchronous reset.
      issue(1'b1, pick(), pick());
      repeat (W / 2) tick();
      rst_n = 1'b0;
      accepted--;
      #1;
      chk($sformatf("w%0d_abort_busy", W), 64'(busy), 64'd0);
      chk($sformatf("w%0d_abort_ready", W), 64'(ready), 64'd1);
      chk($sformatf("w%0d_abort_done", W), 64'(done), 64'd0);
      chk($sformatf("w%0d_abort_product", W), 64'(product), 64'd0);
      repeat (2) tick();
      rst_n      = 1'b1;
      model_free = edge_n + 1;

      // Random traffic; starts raised while busy must be ignored.
      while (accepted < Target + 50) begin
        if (model_free <= edge_n + 1) begin
          if ($urandom_range(0, 1) == 1) begin
            issue(1'($urandom), pick(), pick());
          end else begin
            start = 1'b0;
            tick();
          end
        end else begin
          start       = ($urandom_range(0, 3) == 0);
          a           = pick();
          b           = pick();
          signed_mode = 1'($urandom);
          tick();
        end
      end

      start = 1'b0;
      for (int k = 0; k < W + 5 && exp_q.size() > 0; k++) tick();
      tick();
      chk($sformatf("w%0d_drained", W), 64'(exp_q.size()), 64'd0);
      chk($sformatf("w%0d_done_count", W), 64'(n_done), 64'(accepted));
      fin[gi] = 1'b1;
    end

    // Monitor
    initial begin
      last_prod = '0;
      n_done    = 0;
    end

    always @(negedge clk) begin
      logic exp_busy;
      logic exp_done;
      if (!rst_n) begin
        exp_q.delete();
        last_prod = '0;
        chk($sformatf("w%0d_rst_busy", W), 64'(busy), 64'd0);
        chk($sformatf("w%0d_rst_ready", W), 64'(ready), 64'd1);
        chk($sformatf("w%0d_rst_done", W), 64'(done), 64'd0);
        chk($sformatf("w%0d_rst_product", W), 64'(product), 64'd0);
      end else begin
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (exp_q.size() > 0) begin
          exp_busy = (exp_q[0].acc <= edge_n) && (edge_n < exp_q[0].due);
          exp_done = (exp_q[0].due == edge_n);
        end
        if (done) n_done++;
        if (exp_done) begin
          last_prod = exp_q[0].prod;
          void'(exp_q.pop_front());
        end
        chk($sformatf("w%0d_busy", W), 64'(busy), 64'(exp_busy));
        chk($sformatf("w%0d_ready", W), 64'(ready), 64'(!exp_busy));
        chk($sformatf("w%0d_done", W), 64'(done), 64'(exp_done));
        chk($sformatf("w%0d_product", W), 64'(product), last_prod);
      end
    end
  end

  initial begin
    bit all_fin;
    all_fin = 1'b0;
    for (int c = 0; c < 90000 && !all_fin; c++) begin
      @(posedge clk);
      all_fin = fin[0] && fin[1] && fin[2] && fin[3];
    end
    chk("all_widths_finished", 64'(all_fin), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
